ym6045c_bank_ser_tx: RTL and testbench

YM6045C_BANK_SER_TX -- requirements
Module: ym6045c_bank_ser_tx

---
 rtl/ym6045c_pkg.sv | 22 ++
 rtl/ym6045c_bank_ser_tx_if.sv | 31 +++
 rtl/ym6045c_phase_cnt.sv | 36 +++
 rtl/ym6045c_bank_ser_tx.sv | 146 ++++++++++++++
 tb/tb_ym6045c_bank_ser_tx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ym6045c_pkg.sv
// Shared types and defaults for the YM6045C serial bank-address transmitter.
// Holds the FSM state enumeration, default widths and phase-counter helpers.
package ym6045c_pkg;

  localparam int NBITS_DEF = 9;
  localparam int DIV_DEF   = 4;
  localparam int PHASE_W   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    END    = 3'd4
  } state_e;

  // The phase counter runs DIV-1 down to 0, so the zero flag marks the last cycle.
  function automatic logic [PHASE_W-1:0] phase_reload(input int div);
    return PHASE_W'(div - 1);
  endfunction

endpackage

// File: rtl/ym6045c_bank_ser_tx_if.sv
// Signal bundle for the bank serial transmitter: request side plus serial/status outputs.
// master drives the request side, slave is the transmitter.
interface ym6045c_bank_ser_tx_if
  import ym6045c_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) ();

  // START is a one-cycle request that is only honoured while BUSY=0; there is no
  // back-pressure, so a request during BUSY is dropped. DONE pulses once per transfer.
  logic             START;
  logic [NBITS-1:0] BANK;
  logic             ZWAIT_n;
  logic             ZWR_n;
  logic             ZD0;
  logic             BSEL_n;
  logic             BUSY;
  logic             DONE;
  logic [NBITS-1:0] SHADOW;

  modport master (
    output START, BANK, ZWAIT_n,
    input  ZWR_n, ZD0, BSEL_n, BUSY, DONE, SHADOW
  );

  modport slave (
    input  START, BANK, ZWAIT_n,
    output ZWR_n, ZD0, BSEL_n, BUSY, DONE, SHADOW
  );

endinterface

// File: rtl/ym6045c_phase_cnt.sv
// Load/decrement phase counter with a hold enable and a zero flag.
// Stops at zero; a load always wins over hold.
module ym6045c_phase_cnt
  import ym6045c_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [PHASE_W-1:0] load_val,
  input  logic               hold,
  output logic               zero
);

  logic [PHASE_W-1:0] cnt_q;
  logic [PHASE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ym6045c_bank_ser_tx.sv
// Serial bank-address transmitter: shifts BANK out LSB first as SETUP/STROBE/HOLD
// bit slots, and keeps a SHADOW copy of what the receiver's shift register holds.
module ym6045c_bank_ser_tx
  import ym6045c_pkg::*;
#(
  parameter int NBITS = NBITS_DEF,
  parameter int DIV   = DIV_DEF
) (
  input  logic             MCLK,
  input  logic             nRES,
  input  logic             START,
  input  logic [NBITS-1:0] BANK,
  input  logic             ZWAIT_n,
  output logic             ZWR_n,
  output logic             ZD0,
  output logic             BSEL_n,
  output logic             BUSY,
  output logic             DONE,
  output logic [NBITS-1:0] SHADOW
);

  localparam int                 BCW      = $clog2(NBITS + 1);
  localparam logic [PHASE_W-1:0] RELOAD   = phase_reload(DIV);
  localparam logic [BCW-1:0]     LAST_BIT = BCW'(NBITS - 1);

  ym6045c_bank_ser_tx_if #(.NBITS(NBITS)) bus ();

  state_e           state_q,  state_d;
  logic [NBITS-1:0] shift_q,  shift_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             zwr_n_q,  zwr_n_d;
  logic             zd0_q,    zd0_d;
  logic             bsel_n_q, bsel_n_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic ph_load;
  logic ph_hold;
  logic ph_zero;

  assign bus.START   = START;
  assign bus.BANK    = BANK;
  assign bus.ZWAIT_n = ZWAIT_n;

  ym6045c_phase_cnt u_phase_cnt (
    .clk      (MCLK),
    .rst_n    (nRES),
    .load     (ph_load),
    .load_val (RELOAD),
    .hold     (ph_hold),
    .zero     (ph_zero)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    bit_cnt_d = bit_cnt_q;
    ph_load   = 1'b0;
    ph_hold   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          shift_d   = bus.BANK;
          bit_cnt_d = '0;
          ph_load   = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (ph_zero) begin
          ph_load = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        // A low ZWAIT_n freezes the count and also blocks the exit on an expired count.
        ph_hold = !bus.ZWAIT_n;
        if (ph_zero && bus.ZWAIT_n) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        shift_d   = shift_q >> 1;
        shadow_d  = {zd0_q, shadow_q[NBITS-1:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        ph_load   = 1'b1;
        state_d   = (bit_cnt_q == LAST_BIT) ? END : SETUP;
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with state_q.
    zwr_n_d  = (state_d != STROBE);
    bsel_n_d = !(state_d inside {SETUP, STROBE, HOLD});
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == END);
    zd0_d    = (state_d == SETUP) ? shift_d[0] : zd0_q;
  end

  always_ff @(posedge MCLK or negedge nRES) begin
    if (!nRES) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      shadow_q  <= '0;
      bit_cnt_q <= '0;
      zwr_n_q   <= 1'b1;
      zd0_q     <= 1'b0;
      bsel_n_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      bit_cnt_q <= bit_cnt_d;
      zwr_n_q   <= zwr_n_d;
      zd0_q     <= zd0_d;
      bsel_n_q  <= bsel_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.ZWR_n  = zwr_n_q;
  assign bus.ZD0    = zd0_q;
  assign bus.BSEL_n = bsel_n_q;
  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.SHADOW = shadow_q;

  assign ZWR_n  = bus.ZWR_n;
  assign ZD0    = bus.ZD0;
  assign BSEL_n = bus.BSEL_n;
  assign BUSY   = bus.BUSY;
  assign DONE   = bus.DONE;
  assign SHADOW = bus.SHADOW;

endmodule

// File: tb/tb_ym6045c_bank_ser_tx.sv
// Bench for ym6045c_bank_ser_tx: a DIV=2 and a DIV=1 instance, a negedge monitor that
// records strobes/transfers, and per-scenario tasks checking against a bit-level model.
module tb_ym6045c_bank_ser_tx;
  import ym6045c_pkg::*;

  localparam int NB = 9;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sel   = 1'b0;  // 0: DIV=2 instance, 1: DIV=1 instance
  always #5 clk = ~clk;

  ym6045c_bank_ser_tx_if #(.NBITS(NB)) if_a ();
  ym6045c_bank_ser_tx_if #(.NBITS(NB)) if_b ();

  ym6045c_bank_ser_tx #(.NBITS(NB), .DIV(2)) u_dut_a (
    .MCLK(clk), .nRES(rst_n), .START(if_a.START), .BANK(if_a.BANK), .ZWAIT_n(if_a.ZWAIT_n),
    .ZWR_n(if_a.ZWR_n), .ZD0(if_a.ZD0), .BSEL_n(if_a.BSEL_n), .BUSY(if_a.BUSY),
    .DONE(if_a.DONE), .SHADOW(if_a.SHADOW)
  );

  ym6045c_bank_ser_tx #(.NBITS(NB), .DIV(1)) u_dut_b (
    .MCLK(clk), .nRES(rst_n), .START(if_b.START), .BANK(if_b.BANK), .ZWAIT_n(if_b.ZWAIT_n),
    .ZWR_n(if_b.ZWR_n), .ZD0(if_b.ZD0), .BSEL_n(if_b.BSEL_n), .BUSY(if_b.BUSY),
    .DONE(if_b.DONE), .SHADOW(if_b.SHADOW)
  );

  logic          m_zwr, m_zd0, m_bsel, m_busy, m_done, m_zwait;
  logic [NB-1:0] m_shadow;
  assign m_zwr    = sel ? if_b.ZWR_n   : if_a.ZWR_n;
  assign m_zd0    = sel ? if_b.ZD0     : if_a.ZD0;
  assign m_bsel   = sel ? if_b.BSEL_n  : if_a.BSEL_n;
  assign m_busy   = sel ? if_b.BUSY    : if_a.BUSY;
  assign m_done   = sel ? if_b.DONE    : if_a.DONE;
  assign m_zwait  = sel ? if_b.ZWAIT_n : if_a.ZWAIT_n;
  assign m_shadow = sel ? if_b.SHADOW  : if_a.SHADOW;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [NB-1:0] drv_bank;

  // reference model: expected bits (LSB first) and expected SHADOW per transfer
  logic          exp_bit_q[$];
  logic [NB-1:0] exp_q[$];

  // monitor
  logic          obs_bit_q[$];
  int            obs_len_q[$];
  int            obs_wait_q[$];
  int            obs_busy_q[$];
  logic [NB-1:0] obs_shadow_q[$];
  int            done_cnt, busy_run, cur_len, cur_wait, bsel_bad;
  logic          prev_zwr = 1'b1;

  always @(negedge clk) begin
    if (m_busy) busy_run++;
    if (m_busy && !m_done && m_bsel) bsel_bad++;
    if (!m_zwr) begin
      if (prev_zwr) begin
        obs_bit_q.push_back(m_zd0);
        cur_len  = 0;
        cur_wait = 0;
      end
      cur_len++;
      if (!m_zwait) cur_wait++;
    end else if (!prev_zwr) begin
      obs_len_q.push_back(cur_len);
      obs_wait_q.push_back(cur_wait);
    end
    if (m_done) begin
      done_cnt++;
      obs_shadow_q.push_back(m_shadow);
      obs_busy_q.push_back(busy_run);
      busy_run = 0;
    end
    prev_zwr = m_zwr;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic [NB-1:0] bk, input logic zw);
    drv_bank = bk;
    if (sel) begin
      if_b.START = st; if_b.BANK = bk; if_b.ZWAIT_n = zw;
    end else begin
      if_a.START = st; if_a.BANK = bk; if_a.ZWAIT_n = zw;
    end
  endtask

  task automatic clear_obs();
    obs_bit_q.delete(); obs_len_q.delete(); obs_wait_q.delete();
    obs_busy_q.delete(); obs_shadow_q.delete();
    exp_bit_q.delete(); exp_q.delete();
    done_cnt = 0; busy_run = 0; cur_len = 0; cur_wait = 0; bsel_bad = 0;
    prev_zwr = 1'b1;
  endtask

  task automatic build_exp(input logic [NB-1:0] bank);
    for (int i = 0; i < NB; i++) exp_bit_q.push_back(((bank >> i) & 1) != 0);
    exp_q.push_back(bank);
  endtask

  function automatic int exp_len(input int div, input int waits);
    return NB * (2 * div + 1) + 1 + waits;
  endfunction

  task automatic start_xfer(input logic [NB-1:0] bank);
    tick();
    clear_obs();
    set_in(1'b1, bank, 1'b1);
    tick();
    set_in(1'b0, NB'($urandom), 1'b1);
  endtask

  // mode 0: no waits, 1: random waits, 2: 3 wait cycles in the 4th strobe,
  // 3: START+BANK=0x0FF mid-transfer and START again in the END cycle
  task automatic wait_done(input int mode, input int target, output bit ok);
    int   strobe_no = 0;
    int   waits_left = 3;
    logic prev = 1'b1;
    logic zw, st;
    logic [NB-1:0] bk;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
      if (prev && !m_zwr) strobe_no++;
      prev = m_zwr;
      zw = 1'b1;
      st = 1'b0;
      bk = drv_bank;
      if (mode == 1) zw = ($urandom_range(0, 3) != 0);
      if (mode == 2 && strobe_no == 4 && !m_zwr && waits_left > 0) begin
        zw = 1'b0;
        waits_left--;
      end
      if (mode == 3 && c == 20) begin
        st = 1'b1;
        bk = NB'(9'h0FF);
      end
      if (mode == 3 && m_done) st = 1'b1;
      set_in(st, bk, zw);
    end
    set_in(1'b0, drv_bank, 1'b1);
  endtask

  // scenarios
  task automatic test_reset();
    sel = 1'b1; set_in(1'b0, '0, 1'b1);
    sel = 1'b0; set_in(1'b0, '0, 1'b1);
    rst_n = 1'b0;
    repeat (3) tick();
    chk_cnt++;
    if ({if_a.ZWR_n, if_a.BSEL_n, if_a.ZD0, if_a.BUSY, if_a.DONE} !== 5'b11000) begin
      $display("FAIL reset_ctl_a: got %b want 11000",
               {if_a.ZWR_n, if_a.BSEL_n, if_a.ZD0, if_a.BUSY, if_a.DONE});
    end else pass_cnt++;
    chk_cnt++;
    if ({if_b.ZWR_n, if_b.BSEL_n, if_b.ZD0, if_b.BUSY, if_b.DONE} !== 5'b11000) begin
      $display("FAIL reset_ctl_b: got %b want 11000",
               {if_b.ZWR_n, if_b.BSEL_n, if_b.ZD0, if_b.BUSY, if_b.DONE});
    end else pass_cnt++;
    chk_cnt++;
    if (if_a.SHADOW !== '0 || if_b.SHADOW !== '0) begin
      $display("FAIL reset_shadow: got %h/%h want 000", if_a.SHADOW, if_b.SHADOW);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    chk_cnt++;
    if (if_a.BUSY !== 1'b0 || if_b.BUSY !== 1'b0) begin
      $display("FAIL reset_idle_busy: got %b%b want 00", if_a.BUSY, if_b.BUSY);
    end else pass_cnt++;
  endtask

  task automatic test_basic();
    bit ok;
    logic [NB-1:0] bank = 9'h1A5;
    sel = 1'b0;
    start_xfer(bank);
    build_exp(bank);
    wait_done(0, 1, ok);
    chk_cnt++;
    if (!ok) $display("FAIL basic_timeout: got no DONE want DONE"); else pass_cnt++;
    chk_cnt++;
    if (obs_bit_q.size() != NB) $display("FAIL basic_nstrobe: got %0d want %0d", obs_bit_q.size(), NB);
    else pass_cnt++;
    for (int i = 0; i < NB && i < obs_bit_q.size(); i++) begin
      chk_cnt++;
      if (obs_bit_q[i] !== exp_bit_q[i])
        $display("FAIL basic_bit%0d: got %b want %b", i, obs_bit_q[i], exp_bit_q[i]);
      else pass_cnt++;
      chk_cnt++;
      if (obs_len_q[i] != 2) $display("FAIL basic_len%0d: got %0d want 2", i, obs_len_q[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (obs_busy_q.size() != 1 || obs_busy_q[0] != exp_len(2, 0))
      $display("FAIL basic_length: got %0d want %0d", obs_busy_q.size() ? obs_busy_q[0] : -1, exp_len(2, 0));
    else pass_cnt++;
    chk_cnt++;
    if (obs_shadow_q.size() != 1 || obs_shadow_q[0] !== exp_q[0])
      $display("FAIL basic_shadow: got %h want %h", obs_shadow_q.size() ? obs_shadow_q[0] : 'x, exp_q[0]);
    else pass_cnt++;
    chk_cnt++;
    if (bsel_bad != 0) $display("FAIL basic_bsel: got %0d high cycles want 0", bsel_bad); else pass_cnt++;
    chk_cnt++;
    if ({m_zwr, m_bsel, m_busy, m_zd0} !== {3'b110, exp_bit_q[NB-1]})
      $display("FAIL basic_idle: got %b want %b", {m_zwr, m_bsel, m_busy, m_zd0}, {3'b110, exp_bit_q[NB-1]});
    else pass_cnt++;
  endtask

  task automatic test_wait();
    bit ok;
    sel = 1'b1;
    start_xfer(9'h000);
    build_exp(9'h000);
    wait_done(2, 1, ok);
    chk_cnt++;
    if (!ok) $display("FAIL wait_timeout: got no DONE want DONE"); else pass_cnt++;
    chk_cnt++;
    if (obs_len_q.size() != NB) $display("FAIL wait_nstrobe: got %0d want %0d", obs_len_q.size(), NB);
    else pass_cnt++;
    for (int i = 0; i < NB && i < obs_len_q.size(); i++) begin
      chk_cnt++;
      if (obs_len_q[i] != ((i == 3) ? 4 : 1))
        $display("FAIL wait_len%0d: got %0d want %0d", i, obs_len_q[i], (i == 3) ? 4 : 1);
      else pass_cnt++;
    end
    chk_cnt++;
    if (obs_busy_q.size() != 1 || obs_busy_q[0] != 31)
      $display("FAIL wait_length: got %0d want 31", obs_busy_q.size() ? obs_busy_q[0] : -1);
    else pass_cnt++;
    chk_cnt++;
    if (obs_shadow_q.size() != 1 || obs_shadow_q[0] !== exp_q[0])
      $display("FAIL wait_shadow: got %h want %h", obs_shadow_q.size() ? obs_shadow_q[0] : 'x, exp_q[0]);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    bit ok;
    logic [NB-1:0] bank = NB'($urandom_range(0, 255)) | 9'h100;
    sel = 1'b0;
    start_xfer(bank);
    build_exp(bank);
    wait_done(3, 1, ok);
    repeat (12) tick();
    chk_cnt++;
    if (!ok) $display("FAIL ignore_timeout: got no DONE want DONE"); else pass_cnt++;
    chk_cnt++;
    if (done_cnt != 1) $display("FAIL ignore_done_count: got %0d want 1", done_cnt); else pass_cnt++;
    chk_cnt++;
    if (m_busy !== 1'b0) $display("FAIL ignore_busy_after: got %b want 0", m_busy); else pass_cnt++;
    chk_cnt++;
    if (obs_shadow_q.size() < 1 || obs_shadow_q[0] !== exp_q[0])
      $display("FAIL ignore_shadow: got %h want %h", obs_shadow_q.size() ? obs_shadow_q[0] : 'x, exp_q[0]);
    else pass_cnt++;
    chk_cnt++;
    if (obs_bit_q != exp_bit_q) $display("FAIL ignore_bits: got %0d strobes want %0d matching", obs_bit_q.size(), NB);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b0;
    logic [NB-1:0] bank = NB'($urandom) | 9'h001;
    logic [NB-1:0] bank2 = NB'($urandom);
    sel = 1'b0;
    start_xfer(bank);
    for (int c = 0; c < 200; c++) begin
      tick();
      if (obs_bit_q.size() == 6 && !m_zwr) begin
        ok = 1'b1;
        break;
      end
    end
    chk_cnt++;
    if (!ok) $display("FAIL rstmid_reach: got no strobe 5 want strobe 5"); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({m_zwr, m_bsel, m_busy, m_done} !== 4'b1100)
      $display("FAIL rstmid_ctl: got %b want 1100", {m_zwr, m_bsel, m_busy, m_done});
    else pass_cnt++;
    chk_cnt++;
    if (m_shadow !== '0) $display("FAIL rstmid_shadow: got %h want 000", m_shadow); else pass_cnt++;
    set_in(1'b1, bank2, 1'b1);
    clear_obs();
    build_exp(bank2);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_in(1'b0, NB'($urandom), 1'b1);
    chk_cnt++;
    if (m_busy !== 1'b1) $display("FAIL rstmid_first_edge: got BUSY %b want 1", m_busy); else pass_cnt++;
    wait_done(0, 1, ok);
    chk_cnt++;
    if (!ok) $display("FAIL rstmid_timeout: got no DONE want DONE"); else pass_cnt++;
    chk_cnt++;
    if (obs_shadow_q.size() != 1 || obs_shadow_q[0] !== exp_q[0])
      $display("FAIL rstmid_shadow2: got %h want %h", obs_shadow_q.size() ? obs_shadow_q[0] : 'x, exp_q[0]);
    else pass_cnt++;
    chk_cnt++;
    if (obs_bit_q != exp_bit_q) $display("FAIL rstmid_bits: got %0d strobes want %0d matching", obs_bit_q.size(), NB);
    else pass_cnt++;
    chk_cnt++;
    if (obs_busy_q.size() != 1 || obs_busy_q[0] != exp_len(2, 0))
      $display("FAIL rstmid_length: got %0d want %0d", obs_busy_q.size() ? obs_busy_q[0] : -1, exp_len(2, 0));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    logic [NB-1:0] bank = NB'($urandom);
    sel = 1'b0;
    start_xfer(bank);
    build_exp(bank);
    wait_done(0, 1, ok1);
    set_in(1'b1, 9'h1FF, 1'b1);
    build_exp(9'h1FF);
    tick();
    set_in(1'b0, NB'($urandom), 1'b1);
    wait_done(0, 2, ok2);
    chk_cnt++;
    if (!(ok1 && ok2)) $display("FAIL b2b_timeout: got %b%b want 11", ok1, ok2); else pass_cnt++;
    chk_cnt++;
    if (obs_shadow_q != exp_q) $display("FAIL b2b_shadow: got %0d transfers want %h then %h", obs_shadow_q.size(), exp_q[0], exp_q[1]);
    else pass_cnt++;
    chk_cnt++;
    if (obs_bit_q != exp_bit_q) $display("FAIL b2b_bits: got %0d strobes want %0d matching", obs_bit_q.size(), 2 * NB);
    else pass_cnt++;
    chk_cnt++;
    if (obs_busy_q.size() != 2 || obs_busy_q[1] != exp_len(2, 0))
      $display("FAIL b2b_length: got %0d want %0d", obs_busy_q.size() == 2 ? obs_busy_q[1] : -1, exp_len(2, 0));
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit ok;
    int div, waits;
    logic [NB-1:0] bank;
    for (int k = 0; k < 6; k++) begin
      sel = k[0];
      div = sel ? 1 : 2;
      bank = NB'($urandom);
      start_xfer(bank);
      build_exp(bank);
      wait_done(1, 1, ok);
      waits = 0;
      foreach (obs_wait_q[i]) waits += obs_wait_q[i];
      chk_cnt++;
      if (!ok) $display("FAIL rand%0d_timeout: got no DONE want DONE", k); else pass_cnt++;
      chk_cnt++;
      if (obs_bit_q != exp_bit_q) $display("FAIL rand%0d_bits: got %0d strobes want %0d matching", k, obs_bit_q.size(), NB);
      else pass_cnt++;
      for (int i = 0; i < obs_len_q.size(); i++) begin
        chk_cnt++;
        if (obs_len_q[i] - obs_wait_q[i] != div)
          $display("FAIL rand%0d_len%0d: got %0d-%0d want %0d", k, i, obs_len_q[i], obs_wait_q[i], div);
        else pass_cnt++;
      end
      chk_cnt++;
      if (obs_busy_q.size() != 1 || obs_busy_q[0] != exp_len(div, waits))
        $display("FAIL rand%0d_length: got %0d want %0d", k, obs_busy_q.size() ? obs_busy_q[0] : -1, exp_len(div, waits));
      else pass_cnt++;
      chk_cnt++;
      if (obs_shadow_q.size() != 1 || obs_shadow_q[0] !== exp_q[0])
        $display("FAIL rand%0d_shadow: got %h want %h", k, obs_shadow_q.size() ? obs_shadow_q[0] : 'x, exp_q[0]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
